// File: rtl/dutmem_pkg.sv
// Shared definitions for the memory request controller: FSM encoding and
// the response FIFO depth legality check.
package dutmem_pkg;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_FILL = 1'b1
    } state_e;

    localparam int RSP_DEPTH_MIN = 2;
    localparam int RSP_DEPTH_MAX = 16;

    // Response FIFO depth must be a power of two so pointers wrap for free.
    function automatic bit rsp_depth_ok(input int d);
        return (d >= RSP_DEPTH_MIN) && (d <= RSP_DEPTH_MAX) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// File: rtl/dutmem_master_if.sv
// Request, response, fill-control and memory-port signals of dutmem_master.
// The master modport is the controller's view; slave is the surrounding logic.
interface dutmem_master_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 10
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [AWIDTH-1:0] req_addr;
    logic [DWIDTH-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DWIDTH-1:0] rsp_rdata;
    logic              fill_start;
    logic              busy;
    logic              fill_done;
    logic              mem_ce;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_addr;
    logic [DWIDTH-1:0] mem_din;
    logic [DWIDTH-1:0] mem_dout;

    modport master (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, fill_start, mem_dout,
        output req_ready, rsp_valid, rsp_rdata, busy, fill_done,
               mem_ce, mem_we, mem_addr, mem_din
    );

    modport slave (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, fill_start, mem_dout,
        input  req_ready, rsp_valid, rsp_rdata, busy, fill_done,
               mem_ce, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/dutmem_rsp_fifo.sv
// Read-response FIFO: DWIDTH x DEPTH, same-cycle push/pop, exposes occupancy
// so the controller can issue read credits.
module dutmem_rsp_fifo #(
    parameter int DWIDTH = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [DWIDTH-1:0]        din,
    input  logic                     pop,
    output logic [DWIDTH-1:0]        dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occ
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]       occ_q, occ_d;
    logic              do_push, do_pop;
    logic [DWIDTH-1:0] data_q [DEPTH];

    // Pointer and occupancy update; pointers wrap naturally at a power-of-two depth.
    always_comb begin
        do_push  = push && (occ_q != (PW+1)'(DEPTH));
        do_pop   = pop && (occ_q != '0);
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        occ_d    = occ_q;
        if (do_push && !do_pop)      occ_d = occ_q + (PW+1)'(1);
        else if (!do_push && do_pop) occ_d = occ_q - (PW+1)'(1);
    end

    // Control state, cleared by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Storage is data only; it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) data_q[wr_ptr_q] <= din;
    end

    assign dout  = data_q[rd_ptr_q];
    assign empty = (occ_q == '0);
    assign occ   = occ_q;

    // The credit scheme upstream must never push into a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(push && (occ_q == (PW+1)'(DEPTH))));

endmodule

// File: rtl/dutmem_master.sv
// Request-side controller for a single-port ce/we memory with 1-cycle read
// latency. Issues reads only when a response slot is guaranteed, and runs a
// fill engine that writes FILL_VAL to every address.
module dutmem_master
    import dutmem_pkg::*;
#(
    parameter int              DWIDTH    = 32,
    parameter int              AWIDTH    = 10,
    parameter int              RSP_DEPTH = 4,
    parameter logic [DWIDTH-1:0] FILL_VAL = '0
) (
    input logic              clk,
    input logic              rstn,
    dutmem_master_if.master  bus
);
    localparam int PW = $clog2(RSP_DEPTH);

    if (!rsp_depth_ok(RSP_DEPTH)) begin : g_bad_rsp_depth
        $error("dutmem_master: RSP_DEPTH must be a power of two in 2..16");
    end

    state_e            state_q, state_d;
    logic [AWIDTH-1:0] fill_cnt_q, fill_cnt_d;
    logic              rd_pend_q, rd_pend_d;
    logic              fill_done_q, fill_done_d;
    logic              ready_en_q, ready_en_d;

    logic [PW:0]       occ;
    logic [PW+1:0]     used;
    logic              fifo_empty, accept, pop;
    logic [DWIDTH-1:0] fifo_dout;

    // Credits: FIFO entries plus a read in flight must leave room. Only
    // registered terms count, so a pop this cycle frees nothing until next.
    always_comb begin
        used          = {1'b0, occ} + {{(PW+1){1'b0}}, rd_pend_q};
        bus.req_ready = ready_en_q && (state_q == ST_RUN) && (used < (PW+2)'(RSP_DEPTH));
        accept        = bus.req_valid && bus.req_ready;
        bus.rsp_valid = !fifo_empty;
        bus.rsp_rdata = fifo_dout;
        pop           = bus.rsp_valid && bus.rsp_ready;
        bus.busy      = (state_q == ST_FILL);
        bus.fill_done = fill_done_q;
    end

    // Next state plus memory drive: bus requests in RUN, fill writes in FILL.
    always_comb begin
        state_d      = state_q;
        fill_cnt_d   = fill_cnt_q;
        fill_done_d  = 1'b0;
        ready_en_d   = 1'b1;
        rd_pend_d    = accept && !bus.req_we;
        bus.mem_ce   = accept;
        bus.mem_we   = accept && bus.req_we;
        bus.mem_addr = bus.req_addr;
        bus.mem_din  = bus.req_wdata;
        case (state_q)
            ST_RUN: begin
                if (bus.fill_start) state_d = ST_FILL;
            end
            ST_FILL: begin
                bus.mem_ce   = 1'b1;
                bus.mem_we   = 1'b1;
                bus.mem_addr = fill_cnt_q;
                bus.mem_din  = FILL_VAL;
                fill_cnt_d   = fill_cnt_q + AWIDTH'(1);
                if (fill_cnt_q == '1) begin
                    state_d     = ST_RUN;
                    fill_cnt_d  = '0;
                    fill_done_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Controller state; reset drops any fill or read in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_RUN;
            fill_cnt_q  <= '0;
            rd_pend_q   <= 1'b0;
            fill_done_q <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            rd_pend_q   <= rd_pend_d;
            fill_done_q <= fill_done_d;
            ready_en_q  <= ready_en_d;
        end
    end

    // Read data is valid the cycle after the strobe; capture it then.
    dutmem_rsp_fifo #(
        .DWIDTH (DWIDTH),
        .DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (rd_pend_q),
        .din   (bus.mem_dout),
        .pop   (pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .occ   (occ)
    );

endmodule

// File: tb/tb_dutmem_master.sv
// Bench for dutmem_master: behavioural memory on the memory port, a reference
// array of expected contents and a queue of expected read data in request order.
module tb_dutmem_master;
    localparam int          DW    = 32;
    localparam int          AW    = 4;
    localparam int          RD    = 4;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] FV    = 32'hA5A5A5A5;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    dutmem_master_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

    dutmem_master #(.DWIDTH(DW), .AWIDTH(AW), .RSP_DEPTH(RD), .FILL_VAL(FV)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Single-port memory: registered read, dout holds when not reading.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (bus.mem_ce) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_din;
            else            bus.mem_dout      <= mem[bus.mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Observed responses (collected only; compared inside the tests).
    logic [DW-1:0] got_q[$];
    int            got_cyc[$];
    logic          got_busy[$];
    always @(negedge clk) begin
        if (rstn && bus.rsp_valid && bus.rsp_ready) begin
            got_q.push_back(bus.rsp_rdata);
            got_cyc.push_back(cyc);
            got_busy.push_back(bus.busy);
        end
    end

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold a request until it is taken; updates the reference model on acceptance.
    task automatic do_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output int acc_cyc, output int waited);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        acc_cyc = -1;
        waited  = 0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (bus.req_ready) begin
                acc_cyc = cyc;
                if (we) ref_mem[a] = d;
                else    exp_q.push_back(ref_mem[a]);
                step();
                break;
            end
            step();
            waited++;
        end
        bus.req_valid = 1'b0;
        if (acc_cyc < 0) begin
            checks++; failures++;
            $display("FAIL req_timeout addr=%0d never accepted", a);
        end
    endtask

    task automatic wait_rsp(input int n);
        for (int i = 0; i < 100 && got_q.size() < n; i++) step();
        if (got_q.size() < n) begin
            checks++; failures++;
            $display("FAIL rsp_timeout got=%0d want=%0d", got_q.size(), n);
        end
    endtask

    task automatic clear_q();
        exp_q.delete(); got_q.delete(); got_cyc.delete(); got_busy.delete();
    endtask

    task automatic test_reset();
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 4'd2; bus.req_wdata = '0;
        bus.rsp_ready = 1'b0; bus.fill_start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.rsp_valid, bus.busy, bus.fill_done, bus.mem_ce} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got rsp_valid/busy/fill_done/mem_ce=%b want 0000",
                     {bus.rsp_valid, bus.busy, bus.fill_done, bus.mem_ce});
        end
        bus.req_valid = 1'b0;
        step();
        rstn = 1'b1;
        step();
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready got=%b want=1", bus.req_ready);
        end
    endtask

    task automatic test_basic();
        int acc, w;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 4'd5; bus.req_wdata = 32'hDEADBEEF;
        #1;
        checks++;
        if ({bus.req_ready, bus.mem_ce, bus.mem_we, bus.mem_addr, bus.mem_din} !==
            {3'b111, 4'd5, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL write_drive got ce=%b we=%b addr=%0d din=%h want 1 1 5 deadbeef",
                     bus.mem_ce, bus.mem_we, bus.mem_addr, bus.mem_din);
        end
        ref_mem[5] = 32'hDEADBEEF;
        step();
        bus.req_valid = 1'b0;
        do_req(1'b0, 4'd5, '0, acc, w);
        wait_rsp(1);
        if (got_q.size() > 0) begin
            checks++;
            if (got_q[0] !== 32'hDEADBEEF) begin
                failures++; $display("FAIL basic_data got=%h want=deadbeef", got_q[0]);
            end
            checks++;
            if (got_cyc[0] !== acc + 2) begin
                failures++; $display("FAIL basic_latency got=%0d want=%0d", got_cyc[0] - acc, 2);
            end
        end
        clear_q();
    endtask

    task automatic test_back_to_back();
        int acc, w, wsum;
        bus.rsp_ready = 1'b1;
        for (int a = 0; a < 8; a++) do_req(1'b1, AW'(a), $urandom, acc, w);
        wsum = 0;
        do_req(1'b1, 4'd3, 32'h11, acc, w); wsum += w;
        do_req(1'b0, 4'd3, '0, acc, w);     wsum += w;
        for (int a = 0; a < 8; a++) begin
            do_req(1'b0, AW'(a), '0, acc, w); wsum += w;
        end
        checks++;
        if (wsum !== 0) begin
            failures++; $display("FAIL b2b_stalls got=%0d want=0", wsum);
        end
        wait_rsp(9);
        if (got_q.size() >= 9) begin
            checks++;
            if (got_q[0] !== 32'h11) begin
                failures++; $display("FAIL wr_rd_fwd got=%h want=00000011", got_q[0]);
            end
            for (int i = 1; i < 8; i++) begin
                checks++;
                if (got_cyc[i+1] !== got_cyc[i] + 1) begin
                    failures++; $display("FAIL b2b_rate idx=%0d gap=%0d want=1", i, got_cyc[i+1] - got_cyc[i]);
                end
            end
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            checks++;
            if (got_q[0] !== exp_q[0]) begin
                failures++; $display("FAIL b2b_data got=%h want=%h", got_q[0], exp_q[0]);
            end
            void'(got_q.pop_front()); void'(exp_q.pop_front());
        end
        clear_q();
    endtask

    task automatic test_backpressure();
        int accepted = 0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.req_valid = 1'b1; bus.req_we = 1'b0;
            bus.req_addr  = AW'($urandom_range(7, 0));
            #1;
            if (bus.req_ready) begin
                accepted++;
                exp_q.push_back(ref_mem[bus.req_addr]);
            end
            step();
        end
        bus.req_valid = 1'b0;
        checks++;
        if (accepted !== RD) begin
            failures++; $display("FAIL bp_accepted got=%0d want=%0d", accepted, RD);
        end
        checks++;
        if (bus.req_ready !== 1'b0) begin
            failures++; $display("FAIL bp_ready_full got=%b want=0", bus.req_ready);
        end
        bus.rsp_ready = 1'b1;
        wait_rsp(RD);
        step();
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++; $display("FAIL bp_ready_drained got=%b want=1", bus.req_ready);
        end
        checks++;
        if (got_q.size() !== RD) begin
            failures++; $display("FAIL bp_count got=%0d want=%0d", got_q.size(), RD);
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            checks++;
            if (got_q[0] !== exp_q[0]) begin
                failures++; $display("FAIL bp_data got=%h want=%h", got_q[0], exp_q[0]);
            end
            void'(got_q.pop_front()); void'(exp_q.pop_front());
        end
        clear_q();
    endtask

    task automatic test_fill();
        int busy_cnt = 0, done_cnt = 0, last_busy = -1, done_i = -1, acc, w;
        bus.rsp_ready  = 1'b1;
        bus.fill_start = 1'b1;
        step();
        bus.fill_start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.busy) begin
                busy_cnt++;
                last_busy = i;
                checks++;
                if ({bus.req_ready, bus.mem_ce, bus.mem_we, bus.mem_addr, bus.mem_din} !==
                    {3'b011, AW'(busy_cnt - 1), FV}) begin
                    failures++;
                    $display("FAIL fill_drive cyc=%0d rdy=%b ce=%b we=%b addr=%0d din=%h want 0 1 1 %0d %h",
                             i, bus.req_ready, bus.mem_ce, bus.mem_we, bus.mem_addr, bus.mem_din,
                             busy_cnt - 1, FV);
                end
            end
            if (bus.fill_done) begin
                done_cnt++;
                done_i = i;
            end
            step();
        end
        checks++;
        if (busy_cnt !== DEPTH) begin
            failures++; $display("FAIL fill_busy_cycles got=%0d want=%0d", busy_cnt, DEPTH);
        end
        checks++;
        if (done_cnt !== 1 || done_i !== last_busy + 1) begin
            failures++; $display("FAIL fill_done_pulse got count=%0d at=%0d want 1 at %0d",
                                 done_cnt, done_i, last_busy + 1);
        end
        for (int a = 0; a < DEPTH; a++) ref_mem[a] = FV;
        for (int a = 0; a < DEPTH; a++) do_req(1'b0, AW'(a), '0, acc, w);
        wait_rsp(DEPTH);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            checks++;
            if (got_q[0] !== exp_q[0]) begin
                failures++; $display("FAIL fill_readback got=%h want=%h", got_q[0], exp_q[0]);
            end
            void'(got_q.pop_front()); void'(exp_q.pop_front());
        end
        clear_q();
    endtask

    task automatic test_fill_with_read();
        int acc, w;
        logic [AW-1:0] a = AW'($urandom_range(DEPTH - 1, 0));
        bus.rsp_ready = 1'b1;
        do_req(1'b1, a, $urandom, acc, w);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = a; bus.fill_start = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            failures++; $display("FAIL fillrd_ready got=%b want=1", bus.req_ready);
        end
        exp_q.push_back(ref_mem[a]);
        step();
        bus.req_valid = 1'b0; bus.fill_start = 1'b0;
        wait_rsp(1);
        if (got_q.size() > 0) begin
            checks++;
            if (got_q[0] !== exp_q[0]) begin
                failures++; $display("FAIL fillrd_data got=%h want=%h", got_q[0], exp_q[0]);
            end
            checks++;
            if (got_busy[0] !== 1'b1) begin
                failures++; $display("FAIL fillrd_during_fill got busy=%b want=1", got_busy[0]);
            end
        end
        for (int i = 0; i < 40 && bus.busy; i++) step();
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++; $display("FAIL fillrd_end got busy=%b want=0", bus.busy);
        end
        step();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = FV;
        clear_q();
    endtask

    task automatic test_reset_mid_fill();
        int acc, w, done_seen = 0;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bus.fill_start = 1'b1;
        step();
        bus.fill_start = 1'b0;
        repeat (7) step();
        checks++;
        if (bus.mem_addr !== AW'(7)) begin
            failures++; $display("FAIL midfill_cnt got=%0d want=7", bus.mem_addr);
        end
        rstn = 1'b0;
        #1;
        checks++;
        if ({bus.rsp_valid, bus.busy, bus.fill_done, bus.mem_ce} !== 4'b0000) begin
            failures++;
            $display("FAIL midfill_reset got rsp_valid/busy/fill_done/mem_ce=%b want 0000",
                     {bus.rsp_valid, bus.busy, bus.fill_done, bus.mem_ce});
        end
        for (int i = 0; i < 7; i++) ref_mem[i] = FV;
        clear_q();
        step(); step();
        rstn = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.fill_done || bus.busy) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            failures++; $display("FAIL midfill_no_done got=%0d active cycles want=0", done_seen);
        end
        a = AW'($urandom_range(DEPTH - 1, 0));
        d = $urandom;
        bus.rsp_ready = 1'b1;
        do_req(1'b1, a, d, acc, w);
        do_req(1'b0, a, '0, acc, w);
        wait_rsp(1);
        if (got_q.size() > 0) begin
            checks++;
            if (got_q[0] !== d) begin
                failures++; $display("FAIL after_reset_data got=%h want=%h", got_q[0], d);
            end
        end
        clear_q();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
        bus.rsp_ready = 1'b0; bus.fill_start = 1'b0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_fill();
        test_fill_with_read();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
